// File: rtl/bus_test_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_test_sequencer_if
// Brief    : Run control, stage enables and status of the bus-invert test.
// Revision : 1.0
// ============================================================================
interface bus_test_sequencer_if #(
    parameter int NUM_WORDS = 2000,
    parameter int CNT_W     = 11
);
    localparam int c_WC_W = $clog2(NUM_WORDS + 1);

    logic              start;
    logic              abort;
    logic              err_inj;
    logic              isequal;
    logic              en_gen_data;
    logic              en_enc;
    logic              en_bus;
    logic              en_dec;
    logic              en_trans_count;
    logic              en_k_comp;
    logic              en_gen_err;
    logic              en_bf1;
    logic              en_bf2;
    logic              done;
    logic              busy;
    logic              pass;
    logic [CNT_W-1:0]  err_cnt;
    logic [c_WC_W-1:0] word_cnt;

    // master: the sequencer, which owns every enable and status signal
    modport master (
        input  start, abort, err_inj, isequal,
        output en_gen_data, en_enc, en_bus, en_dec, en_trans_count, en_k_comp,
        output en_gen_err, en_bf1, en_bf2, done, busy, pass, err_cnt, word_cnt
    );

    modport slave (
        output start, abort, err_inj, isequal,
        input  en_gen_data, en_enc, en_bus, en_dec, en_trans_count, en_k_comp,
        input  en_gen_err, en_bf1, en_bf2, done, busy, pass, err_cnt, word_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bus_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bus_test_sequencer
// Brief    : Sequences the staggered datapath enable wave and scores compares.
// Revision : 1.0
// ============================================================================
module bus_test_sequencer #(
    parameter int NUM_WORDS  = 2000,
    parameter int PIPE_DEPTH = 4,
    parameter int CNT_W      = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_test_sequencer_if.master bus
);
    localparam int c_WC_W = $clog2(NUM_WORDS + 1);
    localparam int c_DC_W = $clog2(PIPE_DEPTH + 1);

    localparam logic [c_WC_W-1:0] c_LAST_WORD  = c_WC_W'(NUM_WORDS - 1);
    localparam logic [c_DC_W-1:0] c_LAST_DRAIN = c_DC_W'(PIPE_DEPTH);
    localparam logic [CNT_W-1:0]  c_ERR_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PIPE_DEPTH:0] r_v;
    logic [c_WC_W-1:0] r_word_cnt;
    logic [c_DC_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_pass;

    logic w_issue;
    logic w_chk;
    logic w_accept;
    logic w_abort_run;
    logic w_err_inc;
    logic w_done;
    logic w_busy;

    assign w_issue     = (r_state == S_RUN);
    assign w_chk       = r_v[PIPE_DEPTH];
    assign w_accept    = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_abort_run = (r_state != S_IDLE) && bus.abort;
    // The mismatch from the final chk cycle must land before REPORT samples it
    assign w_err_inc   = w_chk && !bus.isequal && !w_abort_run && (r_err_cnt != c_ERR_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_word_cnt == c_LAST_WORD) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == c_LAST_DRAIN) begin
                    w_state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                w_done      = !bus.abort;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_abort_run) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v         <= '0;
            r_word_cnt  <= '0;
            r_drain_cnt <= '0;
            r_err_cnt   <= '0;
            r_pass      <= 1'b0;
        end else begin
            if (w_abort_run) begin
                r_v <= '0;
            end else begin
                r_v <= {r_v[PIPE_DEPTH-1:0], w_issue};
            end

            if (w_accept) begin
                r_word_cnt <= '0;
            end else if (w_issue && !w_abort_run) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end

            if (w_accept) begin
                r_err_cnt <= '0;
            end else if (w_err_inc) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end

            if (w_accept || w_abort_run) begin
                r_pass <= 1'b0;
            end else if (r_state == S_REPORT) begin
                r_pass <= (r_err_cnt == '0);
            end
        end
    end

    // Stage enables tap the delay line; the k-compare tap needs PIPE_DEPTH >= 3
    assign bus.en_gen_data    = w_issue;
    assign bus.en_enc         = r_v[0];
    assign bus.en_bus         = r_v[1];
    assign bus.en_dec         = r_v[2];
    assign bus.en_trans_count = r_v[2];
    assign bus.en_k_comp      = r_v[PIPE_DEPTH-1];
    assign bus.en_gen_err     = w_issue & bus.err_inj;
    assign bus.en_bf1         = 1'b0;
    assign bus.en_bf2         = 1'b0;
    assign bus.done           = w_done;
    assign bus.busy           = w_busy;
    assign bus.pass           = r_pass;
    assign bus.err_cnt        = r_err_cnt;
    assign bus.word_cnt       = r_word_cnt;
endmodule
`default_nettype wire

// File: tb/tb_bus_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_test_sequencer
// Brief    : Directed bench for bus_test_sequencer with a done scoreboard.
// Revision : 1.0
// ============================================================================
module tb_bus_test_sequencer;
    localparam int N       = 8;
    localparam int PD      = 4;
    localparam int ERR_MAX = 2047;
    localparam int SAT_MAX = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_test_sequencer_if #(.NUM_WORDS(N), .CNT_W(11)) bus_a ();
    bus_test_sequencer_if #(.NUM_WORDS(N), .CNT_W(2))  bus_s ();

    bus_test_sequencer #(.NUM_WORDS(N), .PIPE_DEPTH(PD), .CNT_W(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    bus_test_sequencer #(.NUM_WORDS(N), .PIPE_DEPTH(PD), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    typedef struct {
        int done_cyc;
        int err;
        int err_sat;
    } exp_t;

    exp_t sb[$];

    int cyc       = 0;
    int t         = 0;
    int kill      = 0;
    int exp_err   = 0;
    int exp_sat   = 0;
    int wc        = 0;
    int n_checks  = 0;
    int n_fail    = 0;
    bit have_run  = 1'b0;
    bit exp_pass  = 1'b0;
    bit wc_ok     = 1'b1;
    bit checking  = 1'b0;
    bit pending   = 1'b0;
    bit err_inj_v = 1'b0;

    function automatic bit en_at(int d);
        return have_run && (cyc < kill) && (cyc >= t + 1 + d) && (cyc <= t + N + d);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_inj(input bit v);
        err_inj_v     = v;
        bus_a.err_inj = v;
        bus_s.err_inj = v;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model to the edge.
    task automatic step(input bit s, input bit a, input bit ie, input bit r);
        bit   e_busy;
        bit   e_done;
        exp_t e;
        bus_a.start   = s;  bus_s.start   = s;
        bus_a.abort   = a;  bus_s.abort   = a;
        bus_a.isequal = ie; bus_s.isequal = ie;
        rst           = r;
        #1;
        e_busy = have_run && (cyc < kill) && (cyc >= t + 1) && (cyc <= t + N + 6);
        e_done = e_busy && (cyc == t + N + 6) && !a;
        if (checking) begin
            check("en_gen_data",    bus_a.en_gen_data,    en_at(0));
            check("en_enc",         bus_a.en_enc,         en_at(1));
            check("en_bus",         bus_a.en_bus,         en_at(2));
            check("en_dec",         bus_a.en_dec,         en_at(3));
            check("en_trans_count", bus_a.en_trans_count, en_at(3));
            check("en_k_comp",      bus_a.en_k_comp,      en_at(PD));
            check("en_gen_err",     bus_a.en_gen_err,     en_at(0) && err_inj_v);
            check("en_bf1",         bus_a.en_bf1,         0);
            check("en_bf2",         bus_a.en_bf2,         0);
            check("busy",           bus_a.busy,           e_busy);
            check("done",           bus_a.done,           e_done);
            check("sat_done",       bus_s.done,           e_done);
            check("pass",           bus_a.pass,           exp_pass);
            check("err_cnt",        bus_a.err_cnt,        exp_err);
            check("sat_err_cnt",    bus_s.err_cnt,        exp_sat);
            if (wc_ok) check("word_cnt", bus_a.word_cnt, wc);
            if (sb.size() > 0 && sb[0].done_cyc == cyc && !a) begin
                e = sb.pop_front();
                pending = 1'b0;
                check("sb_done",        bus_a.done,    1);
                check("sb_err_cnt",     bus_a.err_cnt, e.err);
                check("sb_sat_err_cnt", bus_s.err_cnt, e.err_sat);
            end
        end
        if (r) begin
            have_run = 1'b0;
            exp_err  = 0;
            exp_sat  = 0;
            exp_pass = 1'b0;
            wc       = 0;
            wc_ok    = 1'b1;
            if (pending) begin
                sb.delete(sb.size() - 1);
                pending = 1'b0;
            end
        end else if (a && e_busy) begin
            kill     = cyc + 1;
            exp_pass = 1'b0;
            wc_ok    = 1'b0;
            if (pending) begin
                sb.delete(sb.size() - 1);
                pending = 1'b0;
            end
        end else begin
            if (en_at(5) && !ie) begin
                if (exp_err < ERR_MAX) exp_err++;
                if (exp_sat < SAT_MAX) exp_sat++;
                if (pending) begin
                    sb[sb.size() - 1].err     = exp_err;
                    sb[sb.size() - 1].err_sat = exp_sat;
                end
            end
            if (e_busy && cyc == t + N + 6) exp_pass = (exp_err == 0);
            if (en_at(0)) wc++;
            if (!e_busy && s && !a) begin
                have_run = 1'b1;
                t        = cyc;
                kill     = 32'h3fff_ffff;
                exp_err  = 0;
                exp_sat  = 0;
                exp_pass = 1'b0;
                wc       = 0;
                wc_ok    = 1'b1;
                sb.push_back('{cyc + N + 6, 0, 0});
                pending  = 1'b1;
            end
        end
        if (r) checking = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        set_inj(1'b0);

        // Reset held with start high, then a single accepted start: clean run
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1);
        check("reset_busy", bus_a.busy, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (N + 8) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("clean_pass",     bus_a.pass,     1);
        check("clean_err_cnt",  bus_a.err_cnt,  0);
        check("clean_word_cnt", bus_a.word_cnt, N);

        // Mismatches at t+6, t+9 and the last chk cycle t+13
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (N + 8) step(1'b0, 1'b0, !(cyc == t + 6 || cyc == t + 9 || cyc == t + 13), 1'b0);
        check("mis_err_cnt", bus_a.err_cnt, 3);
        check("mis_pass",    bus_a.pass,    0);

        // Every compare fails, with the error generator enabled
        set_inj(1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (N + 8) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_hold",   bus_s.err_cnt, 3);
        check("unsat_errs", bus_a.err_cnt, N);
        set_inj(1'b0);

        // Abort mid-RUN, then a normal run with a start during DRAIN
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (N + 8) step(1'b0, cyc == t + 4, 1'b1, 1'b0);
        check("abort_pass", bus_a.pass, 0);
        check("abort_busy", bus_a.busy, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (N + 8) step(cyc == t + N + 2, 1'b0, 1'b1, 1'b0);
        check("after_abort_pass", bus_a.pass, 1);

        // start and abort together in IDLE: not accepted
        step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("collide_busy", bus_a.busy, 0);

        // Reset mid-run
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (N + 8) step(1'b0, 1'b0, 1'b1, cyc == t + 3);
        check("rst_run_pass", bus_a.pass, 0);

        // Abort in REPORT suppresses done
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (N + 8) step(1'b0, cyc == t + N + 6, 1'b1, 1'b0);

        // start held high: back-to-back runs at the earliest acceptance edge
        repeat (2 * (N + 7) + 2) step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (N + 8) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
